mux8_rr_sched: RTL and testbench

Round-robin scheduler that shares one 8:1 bit multiplexer between eight requesters. It grants one requester at a time, drives the mux select lines S2..S0, and samples the selected data bit into a registered output with a valid strobe. It sits in front of the 8:1 gate-level mux datapath and replaces hand-driven select stimulus with arbitrated, time-sliced access.

---
 rtl/mux8_rr_sched_if.sv | 14 +
 rtl/mux8_rr_sched.sv | 61 ++++++
 tb/tb_mux8_rr_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mux8_rr_sched_if.sv
// mux8_rr_sched_if: request/data/grant/sample bundle between requesters and the round-robin scheduler
// master drives en, req, d and observes gnt, sel, busy, y, y_valid; slave is the scheduler side.
interface mux8_rr_sched_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;
    logic       y_valid;
    modport master (output en, req, d, input gnt, sel, busy, y, y_valid);
    modport slave  (input en, req, d, output gnt, sel, busy, y, y_valid);
endinterface

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin scheduler time-slicing one 8:1 bit mux among eight requesters
// Ports: clk rising-edge clock; rst_n async active-low reset;
//        b.en enable, b.req[7:0] requests, b.d[7:0] data D7..D0 (inputs);
//        b.gnt one-hot grant, b.sel {S2,S1,S0}, b.busy, b.y sampled d[sel], b.y_valid (registered outputs).
module mux8_rr_sched #(
    parameter int HOLD = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux8_rr_sched_if.slave    b
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state, state_nx;
    logic [2:0] ptr, win;
    logic [3:0] cnt;
    logic       found, arb, smp, rel;
    // Scan downwards so the candidate closest to ptr is the last (winning) assignment.
    always_comb begin
        win = ptr;
        found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (b.req[ptr + 3'(k)]) begin
                win = ptr + 3'(k);
                found = 1'b1;
            end
        end
    end
    assign arb = (state == IDLE) && b.en && found;
    assign smp = (state == GRANT) && b.en && b.req[b.sel];
    // A grant ends either on a missed sample or after its last sample.
    assign rel = (state == GRANT) && (!smp || cnt == 4'd0);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb
        state_nx = (state == IDLE) ? (arb ? GRANT : IDLE) : (rel ? IDLE : GRANT);
    always_comb
        b.busy = (state == GRANT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ptr       <= '0;
            cnt       <= '0;
            b.gnt     <= '0;
            b.sel     <= '0;
            b.y       <= 1'b0;
            b.y_valid <= 1'b0;
        end else begin
            b.y_valid <= smp;
            if (smp) b.y <= b.d[b.sel];
            if (arb) begin
                b.gnt <= 8'b1 << win;
                b.sel <= win;
                cnt   <= 4'(HOLD - 1);
            end else if (rel) begin
                b.gnt <= '0;
                ptr   <= b.sel + 3'd1;
            end else if (smp) begin
                cnt <= cnt - 4'd1;
            end
        end
endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb_mux8_rr_sched: scoreboard bench for mux8_rr_sched against a transaction-level grant model
module tb_mux8_rr_sched;
    localparam int HOLD = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass = 0;
    int   n_chk = 0;
    mux8_rr_sched_if b();
    mux8_rr_sched #(.HOLD(HOLD)) dut (.clk(clk), .rst_n(rst_n), .b(b));
    always #5 clk = ~clk;
    // Reference model: who owns the mux, how many samples it still may take, where the search starts.
    int   m_ptr, m_owner, m_left;
    bit   m_busy, m_y, m_yv;
    logic [13:0] exp_q[$];
    function void model_reset();
        m_ptr = 0; m_owner = 0; m_left = 0;
        m_busy = 0; m_y = 0; m_yv = 0;
    endfunction
    function void model_edge(input logic e, input logic [7:0] r, input logic [7:0] dd);
        if (!m_busy) begin
            m_yv = 0;
            if (e && r != 8'h00) begin
                for (int k = 0; k < 8; k++)
                    if (r[(m_ptr + k) % 8]) begin
                        m_owner = (m_ptr + k) % 8;
                        break;
                    end
                m_busy = 1;
                m_left = HOLD;
            end
        end else if (e && r[m_owner]) begin
            m_y = dd[m_owner];
            m_yv = 1;
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_ptr = (m_owner + 1) % 8;
            end
        end else begin
            m_yv = 0;
            m_busy = 0;
            m_ptr = (m_owner + 1) % 8;
        end
    endfunction
    function logic [13:0] expv();
        return {m_busy ? 8'(1 << m_owner) : 8'h00, 3'(m_owner), m_busy, m_y, m_yv};
    endfunction
    function logic [13:0] outs();
        return {b.gnt, b.sel, b.busy, b.y, b.y_valid};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask
    // Called at a falling edge: drive inputs, predict the next rising edge, wait one cycle.
    task automatic step(input logic e, input logic [7:0] r, input logic [7:0] dd);
        b.en = e;
        b.req = r;
        b.d = dd;
        if (!rst_n) model_reset();
        else model_edge(e, r, dd);
        exp_q.push_back(expv());
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;
    endtask
    initial begin
        logic [13:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gnt_sel_busy_y_vld", 32'(outs()), 32'(e));
            end
        end
    end
    initial begin
        logic [7:0] r;
        logic       en_r;
        b.en = 1'b0;
        b.req = 8'hFF;
        b.d = 8'h00;
        model_reset();
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", 32'(outs()), 32'h0);
        @(negedge clk);
        step(1'b0, 8'hFF, 8'h00);
        step(1'b0, 8'hFF, 8'h00);
        rst_n = 1'b1;
        repeat (10) step(1'b0, 8'hFF, 8'($urandom));
        repeat (15) step(1'b1, 8'h20, 8'h20);
        do_reset();
        for (int i = 0; i < 45; i++) step(1'b1, 8'hFF, 8'(i));
        do_reset();
        step(1'b1, 8'h09, 8'hFF);
        step(1'b1, 8'h09, 8'hFF);
        step(1'b1, 8'h09, 8'hFF);
        repeat (8) step(1'b1, 8'h08, 8'hF7);
        do_reset();
        repeat (5) step(1'b1, 8'h80, 8'h80);
        repeat (12) step(1'b1, 8'h81, 8'h01);
        do_reset();
        step(1'b1, 8'h40, 8'h40);
        step(1'b1, 8'h40, 8'h40);
        step(1'b1, 8'h40, 8'h40);
        chk("busy_before_async_rst", 32'(b.busy), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_mid_grant", 32'(outs()), 32'h0);
        @(negedge clk);
        step(1'b1, 8'h41, 8'hFF);
        rst_n = 1'b1;
        repeat (8) step(1'b1, 8'h41, 8'hFF);
        do_reset();
        r = 8'h00;
        repeat (1500) begin
            if ($urandom_range(5) == 0)
                r = ($urandom_range(1) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(7));
            en_r = ($urandom_range(15) != 0);
            step(en_r, r, 8'($urandom));
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
